// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the multiplexed 7-segment path.
//   SEG_A..SEG_G, SEG_DP : bit positions inside the 8-bit cathode word
//   SEG_OFF              : active-low "everything dark" cathode pattern
//   SEG_BLANK            : active-low pattern with all seven segments dark
//   hex_to_seg()         : nibble -> active-low segments {g,f,e,d,c,b,a}
//   clog2()              : ceiling log2 for sizing counters
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment pattern; bit SEG_A is segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_n_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle enable pulse.
//   clk  : board clock
//   rst  : synchronous, active-high; count returns to 0
//   tick : high for one cycle when count == DIV-1, then count wraps to 0
// Everything downstream stays on clk and uses tick as an enable, so there
// is no derived clock anywhere in the display path.
module tick_gen
  import seg7_pkg::*;
#(
  parameter int DIV = 40000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/seg7_scan_n.sv
// seg7_scan_n: DIGITS-digit multiplexed hex display driver.
//   clk, rst    : board clock, synchronous active-high reset
//   wr_en       : one-cycle strobe; captures wr_data/dp_in into the pending
//                 buffer. There is no back-pressure: a write is always
//                 accepted, and a second write before the frame boundary
//                 replaces the first.
//   wr_data     : DIGITS hex nibbles, digit 0 in bits [3:0]
//   dp_in       : decimal point per digit, 1 = lit
//   lz_blank    : level, 1 = blank leading zero digits (never digit 0)
//   pending     : a buffered write is waiting for the next frame boundary
//   frame_start : high during the cycle in which idx wraps to 0
//   an          : anode enables, active-low, one-hot-low
//   cat         : cathodes, active-low, [6:0] = a..g, [7] = dp
// The displayed value only changes at a frame boundary so a digit never
// shows a mix of old and new data within one scan.
module seg7_scan_n
  import seg7_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 40000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic                  pending,
  output logic                  frame_start,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            cat
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int IDX_W  = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic              tick;
  logic              boundary;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] pend_data;
  logic [DIGITS-1:0] pend_dp;
  logic [DATA_W-1:0] disp_data;
  logic [DIGITS-1:0] disp_dp;

  logic [DATA_W-1:0] upper;
  logic              blank;
  logic              dp_bit;
  logic [DIGITS-1:0] an_next;
  logic [7:0]        cat_next;

  tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // With DIGITS=1 IDX_LAST is 0, so every tick is a boundary.
  assign boundary    = tick && (idx == IDX_LAST);
  assign frame_start = boundary;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (tick) begin
      if (idx == IDX_LAST) idx <= '0;
      else                 idx <= idx + 1'b1;
    end
  end

  // Double buffer. A write landing on the boundary cycle goes into
  // pend_* while the display takes the previous pending content; the
  // later assignment to pending keeps the new write flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else begin
      if (boundary) begin
        if (pending) begin
          disp_data <= pend_data;
          disp_dp   <= pend_dp;
        end
        pending <= 1'b0;
      end
      if (wr_en) begin
        pend_data <= wr_data;
        pend_dp   <= dp_in;
        pending   <= 1'b1;
      end
    end
  end

  // Shifting the current digit down to bit 0 gives both its nibble and,
  // in the remaining bits, every more-significant digit for blanking.
  always_comb begin
    upper    = disp_data >> {idx, 2'b00};
    dp_bit   = disp_dp[idx];
    blank    = lz_blank && (idx != '0) && (upper == '0);
    an_next  = ~(DIGITS'(1) << idx);
    cat_next = SEG_OFF;
    cat_next[SEG_DP] = ~dp_bit;
    cat_next[SEG_G:SEG_A] = blank ? SEG_BLANK : hex_to_seg(upper[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      cat <= SEG_OFF;
    end else begin
      an  <= an_next;
      cat <= cat_next;
    end
  end

endmodule

// File: doc/seg7_scan_n.md
Name: seg7_scan_n

Overview:
- Parametrised successor of the fixed 4-digit hex display path driven from the memory-mapped output port.
- Generalised to DIGITS digits with an internal scan-rate divider and per-digit decimal points.
- Adds optional leading-zero blanking and tear-free updates: CPU writes are double-buffered and applied only at a scan-frame boundary.
- Sits between the memory's port output and the board anode/cathode pins, clocked from the board clock.

Parameters:
DIGITS, 4, number of multiplexed digits, legal 1..8
CLK_DIV, 40000, board-clock cycles per digit slot, legal >= 2
DATA_W, 4*DIGITS, derived (localparam), hex nibbles, digit 0 = bits [3:0]

Ports:
clk  in  1  board clock; single clock domain
rst  in  1  synchronous reset, active-high
wr_en  in  1  single-cycle strobe, captures wr_data/dp_in
wr_data  in  DATA_W  hex value to display
dp_in  in  DIGITS  decimal point per digit, 1 = lit
lz_blank  in  1  level, 1 = blank leading zero digits
pending  out  1  1 = a write is buffered, not yet shown
frame_start  out  1  one-cycle pulse when the digit index wraps to 0
an  out  DIGITS  anode enables, active-low, one-hot-low
cat  out  8  cathodes, active-low; [0]=a..[6]=g, [7]=dp

Behaviour:
- Reset (rst=1 at a clk edge), all registers:
  - divider=0, idx=0, disp_reg=0, disp_dp=0, pend_reg=0, pending=0
  - an=all 1s, cat=8'hFF, frame_start=0
  - Reset mid-scan or mid-pending discards the buffered write.
- Divider: counts 0..CLK_DIV-1; tick=1 in the cycle where count==CLK_DIV-1, then count wraps to 0.
- Digit index:
  - On tick, idx advances by 1.
  - idx==DIGITS-1 wraps to 0; that wrap is the frame boundary.
  - DIGITS=1: idx stays at 0; every tick is a frame boundary.
- Frame boundary cycle:
  - frame_start=1 for exactly that cycle.
  - If pending=1, disp_reg/disp_dp load pend_reg and pending clears.
- Writes:
  - wr_en=1 loads pend_reg={wr_data,dp_in} and sets pending=1; a later write before the boundary overwrites the earlier one.
  - wr_en coincident with a boundary: display loads the old pend_reg if pending was 1, otherwise it is unchanged; pend_reg takes the new data; pending=1 after the edge.
- Outputs (registered, one cycle after idx changes):
  - an: bit idx low, others high.
  - cat[6:0]: hex decode of disp_reg nibble idx.
  - Hex decode: 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
  - cat[7]=~disp_dp[idx].
- Leading-zero blanking (lz_blank=1):
  - Digit k is blanked iff k>0 and all nibbles k..DIGITS-1 are 0.
  - Blanked digit: cat[6:0]=7'h7F, its dp still honoured, an still asserted.
  - Digit 0 is never blanked.
  - lz_blank is sampled combinationally per slot; a change takes effect on the next output register update.
- Width rules: idx width = clog2(DIGITS), min 1; divider width = clog2(CLK_DIV).

Decomposition:
- Package seg7_pkg holds:
  - the hex-to-segment function and segment bit-position constants (SEG_A..SEG_G, SEG_DP);
  - the active-low off pattern 8'hFF;
  - a clog2 function.
- Sub-module tick_gen (param DIV) produces the one-cycle tick. It supersedes a divided clock: everything stays on clk, with no generated clocks.

Test Plan:
All scenarios use DIGITS=4, CLK_DIV=4.
1. Reset release -> during rst an=4'hF, cat=8'hFF; one cycle after release an=4'hE, cat=8'hC0 (digit 0, value 0, dp off). Ticks every 4 cycles; an sequence E,D,B,7,E; frame_start pulses once per 16 cycles.
2. wr_en with wr_data=16'h12AF, dp_in=4'b0010 mid-frame -> pending=1 until the next frame_start. In the following frame digits 0..3 show cat 8'h8E, 8'h08, 8'hA4, 8'hF9 (digit 1 dp lit); pending=0.
3. Two writes (16'h1111 then 16'h2222) in one frame -> only 16'h2222 is displayed; 16'h1111 never appears on cat.
4. wr_en=16'h0005 on the exact frame-boundary cycle, pending=0 beforehand -> that frame shows the old value; pending=1; 16'h0005 is displayed from the next boundary.
5. lz_blank=1, value 16'h0050 -> digits 3 and 2 cat[6:0]=7'h7F, digit 1 7'h12, digit 0 7'h40. Value 16'h0000 -> only digit 0 lit (7'h40).
6. rst asserted while pending=1 and idx=2 -> an=4'hF, cat=8'hFF, pending=0; after release the display shows 0 and the buffered value is lost.
